// File: rtl/sound_rom_pkg.sv
// Shared widths, FSM states and the sample-image contents for the sound ROM.
package sound_rom_pkg;
  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W_DEF  = 32;
  localparam int BURST_W_DEF = 4;
  localparam int SAMPLE_W    = 16;

  typedef enum logic {IDLE, BURST} state_e;

  // Sample image word at a given index: two packed samples, the index and its complement.
  function automatic logic [2*SAMPLE_W-1:0] sound_image_word(input logic [SAMPLE_W-1:0] idx);
    return {idx, ~idx};
  endfunction
endpackage

// File: rtl/sound_rom_array.sv
// Synchronous single-port sample ROM: registered address, then READ_LATENCY-1
// data stages. Each stage loads only when the word it tracks moves through, so
// the final stage (readdata) holds between valid beats. Words at or beyond
// DEPTH_WORDS read as zero.
module sound_rom_array
  import sound_rom_pkg::*;
#(
  parameter int    ADDR_W       = ADDR_W_DEF,
  parameter int    DATA_W       = DATA_W_DEF,
  parameter int    DEPTH_WORDS  = 65536,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = "sound.mif"
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [READ_LATENCY-1:0] ld_i,     // [0]: address load, [j]: data stage j load
  input  logic [ADDR_W-1:0]       addr_i,
  output logic [DATA_W-1:0]       rdata_o
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);
  // An empty image name yields a blank ROM.
  localparam bit BLANK = (INIT_FILE == "");

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_c;

  // Address register, loaded once per issued word.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      addr_q <= '0;
    else if (ld_i[0]) addr_q <= addr_i;
  end

  // Lookup with out-of-range masking.
  always_comb begin
    word_c = '0;
    if (!BLANK && ({1'b0, addr_q} < DEPTH_L))
      word_c = DATA_W'(sound_image_word(addr_q[SAMPLE_W-1:0]));
  end

  if (READ_LATENCY == 1) begin : g_lat1
    logic live_q;
    // Output follows the held address once a first word has been issued.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)      live_q <= 1'b0;
      else if (ld_i[0]) live_q <= 1'b1;
    end
    assign rdata_o = live_q ? word_c : '0;
  end else begin : g_latn
    logic [READ_LATENCY-1:1][DATA_W-1:0] dstage_q;
    // Data stages advance only with their tracked word.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) dstage_q <= '0;
      else begin
        if (ld_i[1]) dstage_q[1] <= word_c;
        for (int j = 2; j < READ_LATENCY; j++)
          if (ld_i[j]) dstage_q[j] <= dstage_q[j-1];
      end
    end
    assign rdata_o = dstage_q[READ_LATENCY-1];
  end
endmodule

// File: rtl/sound_rom_responder.sv
// Avalon-MM read-only responder for the sound sample ROM. Single reads stream
// at one word per cycle; bursts hold waitrequest while the remaining words are
// issued. A valid shift register follows every issued word to readdatavalid.
module sound_rom_responder
  import sound_rom_pkg::*;
#(
  parameter int    ADDR_W       = ADDR_W_DEF,
  parameter int    DATA_W       = DATA_W_DEF,
  parameter int    BURST_W      = BURST_W_DEF,
  parameter int    DEPTH_WORDS  = 65536,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = "sound.mif"
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [ADDR_W-1:0]  avmm_data_addr,
  input  logic               avmm_data_read,
  input  logic [BURST_W-1:0] avmm_data_burstcount,
  output logic [DATA_W-1:0]  avmm_data_readdata,
  output logic               avmm_data_waitrequest,
  output logic               avmm_data_readdatavalid
);
  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       next_addr_q, next_addr_d, issue_addr;
  logic [BURST_W-1:0]      remain_q, remain_d, req_len;
  logic                    issue;
  logic [READ_LATENCY-1:0] vld_pipe_q, rom_ld;

  // A zero burstcount means a single word.
  assign req_len = (avmm_data_burstcount == '0) ? BURST_W'(1) : avmm_data_burstcount;

  // Next state, burst bookkeeping and the word issued this cycle.
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remain_d    = remain_q;
    issue       = 1'b0;
    issue_addr  = next_addr_q;
    case (state_q)
      IDLE: begin
        if (avmm_data_read) begin
          issue       = 1'b1;
          issue_addr  = avmm_data_addr;
          next_addr_d = avmm_data_addr + ADDR_W'(1);
          remain_d    = req_len - BURST_W'(1);
          if (req_len != BURST_W'(1)) state_d = BURST;
        end
      end
      BURST: begin
        issue       = 1'b1;
        next_addr_d = next_addr_q + ADDR_W'(1);
        remain_d    = remain_q - BURST_W'(1);
        if (remain_q == BURST_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and burst registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remain_q    <= remain_d;
    end
  end

  // Valid shift register: bit k set means a word was issued k+1 cycles ago.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) vld_pipe_q <= '0;
    else begin
      vld_pipe_q[0] <= issue;
      for (int k = 1; k < READ_LATENCY; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end
  end

  // ROM stage loads line up with the valid bits of the word in each stage.
  always_comb begin
    rom_ld    = '0;
    rom_ld[0] = issue;
    for (int k = 1; k < READ_LATENCY; k++) rom_ld[k] = vld_pipe_q[k-1];
  end

  sound_rom_array #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .READ_LATENCY(READ_LATENCY),
    .INIT_FILE   (INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .resetN (resetN),
    .ld_i   (rom_ld),
    .addr_i (issue_addr),
    .rdata_o(avmm_data_readdata)
  );

  assign avmm_data_waitrequest   = (state_q == BURST);
  assign avmm_data_readdatavalid = vld_pipe_q[READ_LATENCY-1];
endmodule

// File: tb/tb_sound_rom_responder.sv
// Bench for sound_rom_responder: two instances (65536 populated words, and a
// fully populated 2^17 space) share stimulus; a cycle-indexed scoreboard of
// expected returns is built from the acceptance rules and compared each cycle.
module tb_sound_rom_responder;
  logic        clk = 1'b0;
  logic        resetN;
  logic [16:0] addr;
  logic        read;
  logic [3:0]  bc;
  logic [31:0] rd_a, rd_b;
  logic        wr_a, wr_b, v_a, v_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int free_cyc = 0;
  bit last_acc;
  bit          exp_v[int];
  logic [16:0] exp_a[int];
  logic [31:0] last_a, last_b;

  always #5 clk = ~clk;

  sound_rom_responder #(.DEPTH_WORDS(65536)) dut (
    .clk(clk), .resetN(resetN), .avmm_data_addr(addr), .avmm_data_read(read),
    .avmm_data_burstcount(bc), .avmm_data_readdata(rd_a),
    .avmm_data_waitrequest(wr_a), .avmm_data_readdatavalid(v_a));

  sound_rom_responder #(.DEPTH_WORDS(131072)) dut_w (
    .clk(clk), .resetN(resetN), .avmm_data_addr(addr), .avmm_data_read(read),
    .avmm_data_burstcount(bc), .avmm_data_readdata(rd_b),
    .avmm_data_waitrequest(wr_b), .avmm_data_readdatavalid(v_b));

  function automatic logic [31:0] img(input logic [16:0] a, input int depth);
    if (int'(a) < depth) return {a[15:0], ~a[15:0]};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_v.delete();
    exp_a.delete();
    free_cyc = cyc;
    last_a = 32'h0;
    last_b = 32'h0;
  endtask

  // One clock cycle: check outputs at the falling edge, update the model with
  // the inputs currently driven, then advance past the rising edge.
  task automatic tick();
    bit ev, ewr;
    int n;
    @(negedge clk);
    ewr = resetN && (cyc < free_cyc);
    ev  = resetN && exp_v.exists(cyc);
    if (ev) begin
      last_a = img(exp_a[cyc], 65536);
      last_b = img(exp_a[cyc], 131072);
    end
    chk("waitreq_a", {31'b0, wr_a}, {31'b0, ewr});
    chk("waitreq_b", {31'b0, wr_b}, {31'b0, ewr});
    chk("rdvalid_a", {31'b0, v_a}, {31'b0, ev});
    chk("rdvalid_b", {31'b0, v_b}, {31'b0, ev});
    chk("rdata_a", rd_a, last_a);
    chk("rdata_b", rd_b, last_b);
    last_acc = 1'b0;
    if (resetN && read && cyc >= free_cyc) begin
      n = (bc == 4'd0) ? 1 : int'(bc);
      for (int k = 0; k < n; k++) begin
        exp_v[cyc+2+k] = 1'b1;
        exp_a[cyc+2+k] = addr + 17'(k);
      end
      free_cyc = cyc + n;
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    read = 1'b0;
    repeat (n) tick();
  endtask

  // Hold a request until the model says it was accepted (bounded).
  task automatic req(input logic [16:0] a, input logic [3:0] b);
    bit done = 1'b0;
    read = 1'b1; addr = a; bc = b;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      done = last_acc;
    end
    read = 1'b0;
    if (!done) chk("req_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    resetN = 1'b0; read = 1'b0; addr = '0; bc = '0;
    last_a = '0; last_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", {31'b0, wr_a}, 32'h0);
    chk("rst_valid", {31'b0, v_a}, 32'h0);
    chk("rst_rdata", rd_a, 32'h0);
    chk("rst_rdata_b", rd_b, 32'h0);
    resetN = 1'b1;

    // Single read.
    req(17'd35729, 4'd1);
    idle(3);
    chk("lit_single", rd_a, 32'h8B91746E);

    // Burst of four.
    req(17'd100, 4'd4);
    idle(6);
    chk("lit_burst_last", rd_a, 32'h0067FF98);

    // Back-to-back singles, then burstcount 0.
    read = 1'b1; bc = 4'd1;
    addr = 17'd10; tick();
    addr = 17'd11; tick();
    addr = 17'd12; tick();
    idle(3);
    chk("lit_b2b_last", rd_a, 32'h000CFFF3);
    req(17'd5, 4'd0);
    idle(4);
    chk("lit_bc0", rd_a, 32'h0005FFFA);

    // Address wrap, then out-of-range word.
    req(17'h1FFFE, 4'd3);
    idle(6);
    chk("lit_wrap_b", rd_b, 32'h0000FFFF);
    req(17'd65536, 4'd1);
    idle(4);
    chk("lit_oor_a", rd_a, 32'h0);
    chk("lit_oor_b", rd_b, 32'h0000FFFF);

    // Read held through a burst with a different address.
    req(17'd200, 4'd4);
    req(17'd300, 4'd1);
    idle(4);
    chk("lit_held", rd_a, 32'h012CFED3);

    // Reset mid-burst after three valid words.
    read = 1'b1; addr = 17'd1000; bc = 4'd8;
    tick();
    read = 1'b0;
    repeat (4) tick();
    resetN = 1'b0;
    #1;
    chk("midrst_rdata", rd_a, 32'h0);
    chk("midrst_valid", {31'b0, v_a}, 32'h0);
    chk("midrst_waitreq", {31'b0, wr_a}, 32'h0);
    model_reset();
    tick();
    resetN = 1'b1;
    idle(6);
    req(17'd7, 4'd2);
    idle(4);

    // Randomized traffic.
    repeat (400) begin
      read = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       addr = 17'($urandom);
        1:       addr = 17'(65536 - 8 + $urandom_range(0, 15));
        default: addr = 17'(131072 - 8 + $urandom_range(0, 7));
      endcase
      bc = 4'($urandom_range(0, 15));
      tick();
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
